// File: rtl/master_apb_32.sv
// APB4 requester: turns one valid/ready command into a single SETUP/ACCESS
// transfer and returns the result on a valid/ready response channel.
// Every output comes straight from a register. A wait-state counter aborts
// the ACCESS phase if the slave never answers.
module master_apb_32 #(
    parameter int P_ADDR_W   = 32,
    parameter int P_TIMEOUT  = 256,
    parameter int P_TO_CNT_W = 9
) (
    input  logic                i_pclk,
    input  logic                i_preset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [P_ADDR_W-1:0] i_cmd_addr,
    input  logic                i_cmd_write,
    input  logic [31:0]         i_cmd_wdata,
    input  logic [3:0]          i_cmd_strb,
    input  logic [2:0]          i_cmd_prot,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [31:0]         o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_rsp_timeout,
    output logic                o_psel,
    output logic                o_penable,
    output logic [P_ADDR_W-1:0] o_paddr,
    output logic                o_pwrite,
    output logic [31:0]         o_pwdata,
    output logic [2:0]          o_pprot,
    output logic [3:0]          o_pstrb,
    input  logic [31:0]         i_prdata,
    input  logic                i_pready,
    input  logic                i_pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // A zero timeout disables the abort path entirely.
    localparam logic                  TO_EN   = (P_TIMEOUT != 0);
    localparam logic [P_TO_CNT_W-1:0] TO_LAST = P_TO_CNT_W'(TO_EN ? P_TIMEOUT - 1 : 0);

    state_t                state_reg, state_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic                  psel_reg, psel_next;
    logic                  penable_reg, penable_next;
    logic [P_ADDR_W-1:0]   paddr_reg, paddr_next;
    logic                  pwrite_reg, pwrite_next;
    logic [31:0]           pwdata_reg, pwdata_next;
    logic [2:0]            pprot_reg, pprot_next;
    logic [3:0]            pstrb_reg, pstrb_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [31:0]           rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
    logic [P_TO_CNT_W-1:0] to_cnt_reg, to_cnt_next;
    logic [3:0]            strb_gated;

    // Reads never carry byte strobes on the bus.
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
        assign strb_gated[gi] = i_cmd_strb[gi] & i_cmd_write;
    end

    // Next-state and next-output decode; everything holds unless a state acts on it.
    always_comb begin
        state_next       = state_reg;
        cmd_ready_next   = cmd_ready_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        paddr_next       = paddr_reg;
        pwrite_next      = pwrite_reg;
        pwdata_next      = pwdata_reg;
        pprot_next       = pprot_reg;
        pstrb_next       = pstrb_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        to_cnt_next      = to_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready_next = 1'b1;
                if (i_cmd_valid && cmd_ready_reg) begin
                    paddr_next     = i_cmd_addr;
                    pwrite_next    = i_cmd_write;
                    pwdata_next    = i_cmd_wdata;
                    pprot_next     = i_cmd_prot;
                    pstrb_next     = strb_gated;
                    psel_next      = 1'b1;
                    penable_next   = 1'b0;
                    cmd_ready_next = 1'b0;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_next = 1'b1;
                to_cnt_next  = '0;
                state_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle.
                if (i_pready) begin
                    rsp_rdata_next   = pwrite_reg ? 32'h0 : i_prdata;
                    rsp_err_next     = i_pslverr;
                    rsp_timeout_next = 1'b0;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RESP;
                end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
                    rsp_rdata_next   = 32'h0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RESP;
                end else if (!(&to_cnt_reg)) begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset kills any transfer in flight immediately.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            state_reg       <= ST_IDLE;
            cmd_ready_reg   <= 1'b1;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            paddr_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= 32'h0;
            pprot_reg       <= 3'h0;
            pstrb_reg       <= 4'h0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= 32'h0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            to_cnt_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            cmd_ready_reg   <= cmd_ready_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            paddr_reg       <= paddr_next;
            pwrite_reg      <= pwrite_next;
            pwdata_reg      <= pwdata_next;
            pprot_reg       <= pprot_next;
            pstrb_reg       <= pstrb_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            to_cnt_reg      <= to_cnt_next;
        end
    end

    assign o_cmd_ready   = cmd_ready_reg;
    assign o_psel        = psel_reg;
    assign o_penable     = penable_reg;
    assign o_paddr       = paddr_reg;
    assign o_pwrite      = pwrite_reg;
    assign o_pwdata      = pwdata_reg;
    assign o_pprot       = pprot_reg;
    assign o_pstrb       = pstrb_reg;
    assign o_rsp_valid   = rsp_valid_reg;
    assign o_rsp_rdata   = rsp_rdata_reg;
    assign o_rsp_err     = rsp_err_reg;
    assign o_rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_master_apb_32.sv
// Directed bench for master_apb_32. Each transaction is described by its
// slave wait count and response delay. The expected waveform is worked out
// from those numbers, measured in cycles since the command was accepted.
module tb_master_apb_32;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        i_preset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_addr;
    logic        i_cmd_write;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_strb;
    logic [2:0]  i_cmd_prot;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic        o_psel;
    logic        o_penable;
    logic [31:0] o_paddr;
    logic        o_pwrite;
    logic [31:0] o_pwdata;
    logic [2:0]  o_pprot;
    logic [3:0]  o_pstrb;
    logic [31:0] i_prdata;
    logic        i_pready;
    logic        i_pslverr;

    always #5 clk = ~clk;

    master_apb_32 #(
        .P_ADDR_W   (32),
        .P_TIMEOUT  (TO),
        .P_TO_CNT_W (4)
    ) dut (
        .i_pclk        (clk),
        .i_preset      (i_preset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_wdata   (i_cmd_wdata),
        .i_cmd_strb    (i_cmd_strb),
        .i_cmd_prot    (i_cmd_prot),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_psel        (o_psel),
        .o_penable     (o_penable),
        .o_paddr       (o_paddr),
        .o_pwrite      (o_pwrite),
        .o_pwdata      (o_pwdata),
        .o_pprot       (o_pprot),
        .o_pstrb       (o_pstrb),
        .i_prdata      (i_prdata),
        .i_pready      (i_pready),
        .i_pslverr     (i_pslverr)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model state
    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    int          m_t, m_a, m_d;
    bit          m_wr, m_tmo, m_slverr;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;

    // Observations per transaction
    int          obs_psel, obs_pen, obs_rsp, obs_rise_t;
    logic [31:0] obs_rdata;
    logic        obs_err, obs_tmo;
    logic        prev_rsp = 1'b0;

    logic [3:0]  exp_ctl;
    logic [31:0] exp_rdata;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    // Per-cycle compare: SETUP at t=1, ACCESS for A cycles, then response until consumed.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!active || m_t == 0)  exp_ctl = 4'b1000;
            else if (m_t == 1)        exp_ctl = 4'b0100;
            else if (m_t <= 1 + m_a)  exp_ctl = 4'b0110;
            else                      exp_ctl = 4'b0001;
            check("ctl{cmd_ready,psel,penable,rsp_valid}",
                  80'({o_cmd_ready, o_psel, o_penable, o_rsp_valid}), 80'(exp_ctl));
            if (active && m_t >= 1 && m_t <= 1 + m_a)
                check("apb_fields", {o_paddr, o_pwrite, o_pwdata, o_pstrb, o_pprot, 8'h0},
                      {m_addr, m_wr, m_wdata, (m_wr ? m_strb : 4'h0), m_prot, 8'h0});
            if (active && m_t >= 2 + m_a) begin
                exp_rdata = (m_wr || m_tmo) ? 32'h0 : m_rd;
                check("rsp_fields", 80'({o_rsp_rdata, o_rsp_err, o_rsp_timeout}),
                      80'({exp_rdata, m_tmo | m_slverr, m_tmo}));
            end
            if (active) begin
                obs_psel += int'(o_psel);
                obs_pen  += int'(o_penable);
                obs_rsp  += int'(o_rsp_valid);
                if (o_rsp_valid && !prev_rsp) begin
                    obs_rise_t = m_t;
                    obs_rdata  = o_rsp_rdata;
                    obs_err    = o_rsp_err;
                    obs_tmo    = o_rsp_timeout;
                end
            end
        end
        prev_rsp = o_rsp_valid;
    end

    // Runs one command. Called just after a posedge with the DUT idle.
    // waits: ACCESS cycles before pready; dly: cycles rsp_ready is held low;
    // hold: keep cmd_valid high with other data during the transfer;
    // abort_at: assert reset in that cycle (0 = never).
    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot, input int waits, input logic [31:0] rd,
                           input bit slverr, input int dly, input bit hold, input int abort_at);
        int last;
        m_wr = wr; m_addr = addr; m_wdata = wdata; m_strb = strb; m_prot = prot;
        m_rd = rd; m_slverr = slverr; m_d = dly;
        m_tmo = (waits + 1 > TO);
        m_a   = m_tmo ? TO : waits + 1;
        obs_psel = 0; obs_pen = 0; obs_rsp = 0; obs_rise_t = -1;
        obs_rdata = 32'hx; obs_err = 1'bx; obs_tmo = 1'bx;
        i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_write = wr;
        i_cmd_wdata = wdata; i_cmd_strb = strb; i_cmd_prot = prot;
        m_t = 0; active = 1'b1;
        last = 3 + m_a + m_d;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            m_t = t;
            if (t == last) active = 1'b0;
            i_cmd_valid = hold && (t < last);
            if (hold) begin
                i_cmd_addr = ~addr; i_cmd_write = ~wr; i_cmd_wdata = ~wdata;
            end
            i_pready    = !m_tmo && (t == waits + 2);
            i_pslverr   = (t == waits + 2) ? slverr : 1'b1;
            i_prdata    = (t == waits + 2) ? rd : (32'hBAD0_0000 | 32'(t));
            i_rsp_ready = (t == 2 + m_a + m_d);
            if (t == abort_at) begin
                @(negedge clk); #1;
                chk_en = 1'b0;
                #2 i_preset = 1'b1;
                #1 check("async_reset_ctl",
                         80'({o_cmd_ready, o_psel, o_penable, o_rsp_valid}), 80'(4'b1000));
                i_cmd_valid = 1'b0; i_pready = 1'b0; i_rsp_ready = 1'b0; active = 1'b0;
                @(posedge clk); #1;
                i_preset = 1'b0;
                chk_en = 1'b1;
                $display("[TB] txn %s: reset asserted at t=%0d", tag, t);
                return;
            end
        end
        i_pready = 1'b0;
        $display("[TB] txn %s: psel=%0d penable=%0d rsp_cycles=%0d rise_t=%0d rdata=%08h err=%0b tmo=%0b",
                 tag, obs_psel, obs_pen, obs_rsp, obs_rise_t, obs_rdata, obs_err, obs_tmo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_preset = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_write = 1'b0;
        i_cmd_wdata = '0; i_cmd_strb = '0; i_cmd_prot = '0; i_rsp_ready = 1'b0;
        i_prdata = '0; i_pready = 1'b0; i_pslverr = 1'b0;
        m_t = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 80'({o_cmd_ready, o_psel, o_penable, o_rsp_valid}), 80'(4'b1000));
        check("reset_apb", {o_paddr, o_pwrite, o_pwdata, o_pstrb, o_pprot, 8'h0}, 80'h0);
        check("reset_rsp", 80'({o_rsp_rdata, o_rsp_err, o_rsp_timeout}), 80'h0);
        @(posedge clk); #1;
        i_preset = 1'b0;
        chk_en = 1'b1;

        run_txn("zero_wait_write", 1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 3'h0,
                0, 32'h1111_2222, 1'b0, 0, 1'b0, 0);
        check("zw_rise_t", 80'(obs_rise_t), 80'd3);
        check("zw_penable_cycles", 80'(obs_pen), 80'd1);
        check("zw_rsp", 80'({obs_rdata, obs_err, obs_tmo}), 80'({32'h0, 1'b0, 1'b0}));

        run_txn("read_3_waits", 1'b0, 32'h0000_0024, 32'h0, 4'hF, 3'h2,
                3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0);
        check("r3_penable_cycles", 80'(obs_pen), 80'd4);
        check("r3_rise_t", 80'(obs_rise_t), 80'd6);
        check("r3_rdata", 80'(obs_rdata), 80'hDEAD_BEEF);

        run_txn("slave_error", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'h1,
                1, 32'h0BAD_F00D, 1'b1, 0, 1'b0, 0);
        check("se_err_tmo", 80'({obs_err, obs_tmo}), 80'(2'b10));

        run_txn("timeout", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'h0,
                100, 32'h1234_5678, 1'b0, 0, 1'b0, 0);
        check("to_psel_cycles", 80'(obs_psel), 80'd9);
        check("to_penable_cycles", 80'(obs_pen), 80'd8);
        check("to_rsp", 80'({obs_rdata, obs_err, obs_tmo}), 80'({32'h0, 1'b1, 1'b1}));

        run_txn("ready_on_last_cycle", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'h4,
                7, 32'hCAFE_0007, 1'b0, 0, 1'b0, 0);
        check("rl_penable_cycles", 80'(obs_pen), 80'd8);
        check("rl_rsp", 80'({obs_rdata, obs_err, obs_tmo}), 80'({32'hCAFE_0007, 1'b0, 1'b0}));

        run_txn("backpressure", 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h5, 3'h3,
                0, 32'h0, 1'b0, 5, 1'b1, 0);
        check("bp_rsp_cycles", 80'(obs_rsp), 80'd6);
        check("bp_psel_cycles", 80'(obs_psel), 80'd2);

        run_txn("reset_mid_access", 1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'h0,
                5, 32'h7777_7777, 1'b0, 0, 1'b0, 4);

        run_txn("after_reset_write", 1'b1, 32'h0000_0060, 32'h0102_0304, 4'h3, 3'h7,
                2, 32'h0, 1'b0, 1, 1'b0, 0);
        check("ar_rise_t", 80'(obs_rise_t), 80'd5);
        check("ar_rsp", 80'({obs_rdata, obs_err, obs_tmo}), 80'({32'h0, 1'b0, 1'b0}));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/master_apb_32.md
Name: master_apb_32

Overview:
- APB4 requester (master) that drives the 32-bit APB slave ports of the peripheral register blocks.
- Converts a simple valid/ready command interface from the local controller into single APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Includes a programmable wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- P_ADDR_W, 32, APB address width.
- P_TIMEOUT, 256, max ACCESS cycles waiting for i_pready before abort; 0 disables timeout.
- P_TO_CNT_W, 9, timeout counter width; must hold P_TIMEOUT.

Ports:
- i_pclk  in  1  clock
- i_preset  in  1  asynchronous reset, active-high
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_addr  in  P_ADDR_W  transfer address
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_wdata  in  32  write data
- i_cmd_strb  in  4  write byte strobes
- i_cmd_prot  in  3  protection attributes
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  32  read data (0 for writes and timeouts)
- o_rsp_err  out  1  slave error or timeout
- o_rsp_timeout  out  1  error caused by timeout
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_paddr  out  P_ADDR_W  APB address
- o_pwrite  out  1  APB direction
- o_pwdata  out  32  APB write data
- o_pprot  out  3  APB protection
- o_pstrb  out  4  APB strobes
- i_prdata  in  32  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release of state): state IDLE; all outputs 0 except o_cmd_ready=1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid, latch addr/write/wdata/strb/prot into the o_p* registers and go to SETUP.
  - o_pstrb is forced to 4'h0 when i_cmd_write=0.
- SETUP (exactly 1 cycle): o_psel=1, o_penable=0, o_cmd_ready=0; go to ACCESS.
- ACCESS:
  - o_psel=1, o_penable=1; address, control and write data stay stable.
  - Timeout counter clears on entry and increments each cycle that i_pready=0.
  - i_pready=1: capture o_rsp_rdata = write ? 0 : i_prdata; o_rsp_err = i_pslverr; o_rsp_timeout=0. Drop psel/penable and go to RESP.
  - Counter reaches P_TIMEOUT-1 with i_pready still 0 (P_TIMEOUT≠0): abort. Drop psel/penable; o_rsp_rdata=0, o_rsp_err=1, o_rsp_timeout=1; go to RESP.
  - i_pready and timeout in the same cycle: i_pready wins.
- RESP:
  - o_rsp_valid=1 and response fields held stable until i_rsp_ready=1.
  - Then o_rsp_valid=0, o_cmd_ready=1, go to IDLE.
  - No back-to-back pipelining; one transfer is outstanding at a time.
- Latency:
  - Command accepted at edge N → SETUP visible N+1 → ACCESS N+2.
  - With zero wait states, o_rsp_valid rises at N+3.
  - Each wait state adds 1 cycle.
- i_pslverr is sampled only when i_pready=1 in ACCESS.
- o_psel is never high outside SETUP/ACCESS.
- Reset asserted mid-transfer: immediate return to IDLE. psel, penable and rsp_valid drop asynchronously; the pending response is discarded.
- Timeout counter saturates and never wraps.

Test Plan:
- Zero-wait write: cmd addr=0x0000_0010, wdata=0xA5A5_1234, strb=0xF, i_pready=1 → SETUP one cycle; ACCESS one cycle with pwdata=0xA5A5_1234, pstrb=0xF; rsp_valid at N+3 with err=0, rdata=0.
- Read with 3 wait states: addr=0x24, slave returns 0xDEAD_BEEF on the 4th ACCESS cycle → penable high 4 cycles, pstrb=0, rsp_rdata=0xDEAD_BEEF at N+6.
- Slave error: read with i_pslverr=1 on the pready cycle → rsp_err=1, rsp_timeout=0.
- Timeout: P_TIMEOUT=8, i_pready held 0 → psel drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rdata=0.
- Response backpressure: i_rsp_ready=0 for 5 cycles → rsp_valid and fields held stable, cmd_ready=0, no new SETUP; accept proceeds after ready.
- Reset mid-ACCESS: assert i_preset during a wait state → psel, penable and rsp_valid go 0 without a clock edge; after release cmd_ready=1 and the next command completes normally.
